// File: rtl/seg7_value_display.sv
// Accepts an 8-bit value, converts it to BCD one bit per cycle (double-dabble),
// and shows it on a multiplexed 3-digit active-low seven-segment display with leading-zero blanking.
module seg7_value_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       ready,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [15:0] scan_q, scan_d;
    logic [1:0]  digit_q, digit_d;

    logic [11:0] bcd_adj;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        scan_d  = scan_q;
        digit_d = digit_q;

        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d = value_in;
                    bcd_d   = 12'd0;
                    iter_d  = 3'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    hund_d  = bcd_d[11:8];
                    tens_d  = bcd_d[7:4];
                    ones_d  = bcd_d[3:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Digit scan is free-running and independent of the conversion.
        if (scan_q == SCAN_LAST) begin
            scan_d  = 16'd0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            scan_d = scan_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= 3'd0;
            shift_q <= 8'd0;
            bcd_q   <= 12'd0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            scan_q  <= 16'd0;
            digit_q <= 2'd0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [3:0] cur_digit;
    logic       blank;

    // Outputs depend only on registered state, never on value_in/value_valid.
    always_comb begin
        cur_digit = ones_q;
        blank     = 1'b0;
        an        = 4'b1111;
        case (digit_q)
            2'd0: cur_digit = ones_q;
            2'd1: begin
                cur_digit = tens_q;
                blank     = (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                cur_digit = hund_q;
                blank     = (hund_q == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        if (!blank) begin
            an[digit_q] = 1'b0;
        end
        seg = blank ? 7'b1111111 : seg_decode(cur_digit);
    end

    assign ready = (state_q == IDLE);
    assign busy  = !ready;
    assign dp    = 1'b1;

endmodule
